// File: rtl/fir_stream_sequencer.sv
// Block sequencer for the FIR datapath: primes filter history with zeros, streams
// one block of samples from the sample RAM, and writes each result to the output RAM.
module fir_stream_sequencer #(
    parameter int N       = 16,
    parameter int AW      = 5,
    parameter int TAPS    = 8,
    parameter int LATENCY = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [N-1:0]  mem_rdata,
    output logic [N-1:0]  Xin,
    input  logic [N-1:0]  Yout,
    output logic          out_we,
    output logic [AW-1:0] out_addr,
    output logic [N-1:0]  out_wdata,
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);
    localparam int PCW = (TAPS > 2) ? $clog2(TAPS-1) : 1;
    localparam logic [PCW-1:0] PRIME_LAST = PCW'((TAPS > 1) ? TAPS-2 : 0);

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t         state;
    logic [AW:0]    len_q;
    logic [AW:0]    rd_ptr;
    logic [AW:0]    wr_ptr;
    logic [PCW-1:0] prime_cnt;
    logic           s_vld;
    logic [LATENCY:0] vld_pipe;
    logic           y_vld;
    logic [AW:0]    len_clamped;

    assign len_clamped = (len > DEPTH) ? DEPTH : len;
    assign y_vld       = vld_pipe[LATENCY];
    assign out_we      = y_vld;
    assign out_addr    = wr_ptr[AW-1:0];
    assign out_wdata   = Yout;

    // Sample stage plus result-valid delay line; vld_pipe[0] travels alongside Xin.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s_vld    <= 1'b0;
            Xin      <= '0;
            vld_pipe <= '0;
        end else begin
            s_vld       <= mem_rd;
            Xin         <= s_vld ? mem_rdata : '0;
            vld_pipe[0] <= s_vld;
            for (int i = 1; i <= LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            len_q     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            prime_cnt <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (y_vld)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len_q     <= len_clamped;
                        rd_ptr    <= '0;
                        wr_ptr    <= '0;
                        prime_cnt <= '0;
                        busy      <= 1'b1;
                        if (len_clamped == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (TAPS == 1) begin
                            state    <= S_STREAM;
                            mem_rd   <= 1'b1;
                            mem_addr <= '0;
                            rd_ptr   <= (AW+1)'(1);
                        end else begin
                            state <= S_PRIME;
                        end
                    end
                end
                S_PRIME: begin
                    // The first read is issued on the edge that ends the last prime cycle.
                    if (prime_cnt == PRIME_LAST) begin
                        state    <= S_STREAM;
                        mem_rd   <= 1'b1;
                        mem_addr <= '0;
                        rd_ptr   <= (AW+1)'(1);
                    end else begin
                        prime_cnt <= prime_cnt + PCW'(1);
                    end
                end
                S_STREAM: begin
                    if (rd_ptr == len_q) begin
                        mem_rd <= 1'b0;
                        state  <= S_DRAIN;
                    end else begin
                        mem_addr <= rd_ptr[AW-1:0];
                        rd_ptr   <= rd_ptr + (AW+1)'(1);
                    end
                end
                S_DRAIN: begin
                    if (y_vld && wr_ptr == len_q - (AW+1)'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
